wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter_pkg.sv | 13 +
 rtl/wb_arb_rr_select.sv | 44 ++++
 rtl/wb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared Wishbone widths and arbiter state encodings.
// Imported by wb_arbiter and wb_arb_rr_select.
package wb_arbiter_pkg;

   localparam int ADR_WIDTH = 64;
   localparam int DAT_WIDTH = 64;
   localparam int SEL_WIDTH = 8;

   localparam logic [1:0] ARB_IDLE     = 2'd0;
   localparam logic [1:0] ARB_OWNED    = 2'd1;
   localparam logic [1:0] ARB_ERR_HOLD = 2'd2;

endpackage

// File: rtl/wb_arb_rr_select.sv
// Combinational round-robin picker.
// Ports: req_i (requests), last_i (previous owner index),
//        gnt_o (one-hot winner), idx_o (winner index), vld_o (any request).
module wb_arb_rr_select
   import wb_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [IDX_W-1:0]       last_i,
   output logic [NUM_MASTERS-1:0] gnt_o,
   output logic [IDX_W-1:0]       idx_o,
   output logic                   vld_o
);

   int                       start;
   int                       pos;
   logic [2*NUM_MASTERS-1:0] dbl;
   logic [NUM_MASTERS-1:0]   rot;

   // Rotate requests so bit 0 is the master after last_i, then take
   // the lowest set bit. Index arithmetic wraps explicitly below N.
   always_comb begin
      start = int'(last_i) + 1;
      if (start >= NUM_MASTERS) start = 0;
      dbl   = {req_i, req_i} >> start;
      rot   = dbl[NUM_MASTERS-1:0];
      pos   = 0;
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (!vld_o && rot[i]) begin
            vld_o = 1'b1;
            pos   = start + i;
            if (pos >= NUM_MASTERS) pos = pos - NUM_MASTERS;
            idx_o = IDX_W'(pos);
            gnt_o = NUM_MASTERS'(1) << pos;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave.
// Ports: clk_i/rst_i; m_* packed master side (slice k = master k);
//        s_* slave side; gnt_o one-hot owner; busy_o bus owned.
// Option: WB_ARB_TIMEOUT_EN adds a stall timeout with ERR_HOLD state.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NUM_MASTERS*ADR_WIDTH-1:0] m_adr_i,
   input  logic [NUM_MASTERS*DAT_WIDTH-1:0] m_dat_i,
   input  logic [NUM_MASTERS*SEL_WIDTH-1:0] m_sel_i,
   input  logic [NUM_MASTERS-1:0]         m_we_i,
   input  logic [NUM_MASTERS-1:0]         m_stb_i,
   input  logic [NUM_MASTERS-1:0]         m_cyc_i,
   output logic [DAT_WIDTH-1:0]           m_dat_o,
   output logic [NUM_MASTERS-1:0]         m_ack_o,
   output logic [NUM_MASTERS-1:0]         m_err_o,
   output logic [ADR_WIDTH-1:0]           s_adr_o,
   output logic [DAT_WIDTH-1:0]           s_dat_o,
   output logic [SEL_WIDTH-1:0]           s_sel_o,
   output logic                           s_we_o,
   output logic                           s_stb_o,
   output logic                           s_cyc_o,
   input  logic [DAT_WIDTH-1:0]           s_dat_i,
   input  logic                           s_ack_i,
   input  logic                           s_err_i,
   output logic [NUM_MASTERS-1:0]         gnt_o,
   output logic                           busy_o
);

   localparam int IW = $clog2(NUM_MASTERS);

   logic [1:0]             state_q, state_d;
   logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
   logic [IW-1:0]          gidx_q, gidx_d;
   logic [IW-1:0]          last_q, last_d;

   logic [NUM_MASTERS-1:0] sel_gnt;
   logic [IW-1:0]          sel_idx;
   logic                   sel_vld;

   logic                   owned;
   logic                   owner_cyc;
   logic                   tmo_hit;

   logic [ADR_WIDTH-1:0]   adr_mux;
   logic [DAT_WIDTH-1:0]   dat_mux;
   logic [SEL_WIDTH-1:0]   sel_mux;
   logic                   we_mux;
   logic                   stb_mux;
   logic                   cyc_mux;

   wb_arb_rr_select #(
      .NUM_MASTERS (NUM_MASTERS),
      .IDX_W       (IW)
   ) u_sel (
      .req_i  (m_cyc_i),
      .last_i (last_q),
      .gnt_o  (sel_gnt),
      .idx_o  (sel_idx),
      .vld_o  (sel_vld)
   );

   assign owned     = (state_q == ARB_OWNED);
   assign owner_cyc = |(m_cyc_i & gnt_q);

   // AND-OR mux on the one-hot grant; all zero when nobody owns.
   always_comb begin
      adr_mux = '0;
      dat_mux = '0;
      sel_mux = '0;
      we_mux  = 1'b0;
      stb_mux = 1'b0;
      cyc_mux = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (gnt_q[k]) begin
            adr_mux = m_adr_i[k*ADR_WIDTH +: ADR_WIDTH];
            dat_mux = m_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
            sel_mux = m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
            we_mux  = m_we_i[k];
            stb_mux = m_stb_i[k];
            cyc_mux = m_cyc_i[k];
         end
      end
   end

   assign s_adr_o = owned ? adr_mux : '0;
   assign s_dat_o = owned ? dat_mux : '0;
   assign s_sel_o = owned ? sel_mux : '0;
   assign s_we_o  = owned & we_mux;
   assign s_stb_o = owned & stb_mux;
   assign s_cyc_o = owned & cyc_mux;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tmo_q, tmo_d;

   assign tmo_hit = owned && (tmo_q == TW'(TIMEOUT_CYCLES));

   // Counts consecutive stalled strobe cycles of the owner.
   always_comb begin
      tmo_d = '0;
      if (owned && !tmo_hit && s_stb_o && !s_ack_i && !s_err_i)
         tmo_d = tmo_q + TW'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) tmo_q <= '0;
      else       tmo_q <= tmo_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   assign m_dat_o = s_dat_i;
   assign m_ack_o = (owned && s_ack_i) ? gnt_q : '0;
   assign m_err_o = (owned && (s_err_i || tmo_hit)) ? gnt_q : '0;
   assign gnt_o   = gnt_q;
   assign busy_o  = (state_q != ARB_IDLE);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      case (state_q)
         ARB_IDLE: begin
            if (sel_vld) begin
               state_d = ARB_OWNED;
               gnt_d   = sel_gnt;
               gidx_d  = sel_idx;
            end
         end
         ARB_OWNED: begin
            if (!owner_cyc) begin
               state_d = ARB_IDLE;
               gnt_d   = '0;
               last_d  = gidx_q;
            end else if (tmo_hit) begin
               state_d = ARB_ERR_HOLD;
            end
         end
`ifdef WB_ARB_TIMEOUT_EN
         ARB_ERR_HOLD: begin
            if (!owner_cyc) begin
               state_d = ARB_IDLE;
               gnt_d   = '0;
               last_d  = gidx_q;
            end
         end
`endif
         default: begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         gidx_q  <= '0;
         last_q  <= IW'(NUM_MASTERS - 1);
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with two masters.
// Table of per-cycle vectors plus reset, fairness and timeout sequences.
module tb_wb_arbiter;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic [1:0]   cyc, stb, we;
   logic [63:0]  adr0, adr1, dat0, dat1;
   logic [7:0]   sel0, sel1;
   logic [63:0]  s_dat_i;
   logic         s_ack_i, s_err_i;

   logic [63:0]  m_dat_o;
   logic [1:0]   m_ack_o, m_err_o;
   logic [63:0]  s_adr_o, s_dat_o;
   logic [7:0]   s_sel_o;
   logic         s_we_o, s_stb_o, s_cyc_o;
   logic [1:0]   gnt_o;
   logic         busy_o;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   wb_arbiter #(
      .NUM_MASTERS    (2),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .m_adr_i ({adr1, adr0}),
      .m_dat_i ({dat1, dat0}),
      .m_sel_i ({sel1, sel0}),
      .m_we_i  (we),
      .m_stb_i (stb),
      .m_cyc_i (cyc),
      .m_dat_o (m_dat_o),
      .m_ack_o (m_ack_o),
      .m_err_o (m_err_o),
      .s_adr_o (s_adr_o),
      .s_dat_o (s_dat_o),
      .s_sel_o (s_sel_o),
      .s_we_o  (s_we_o),
      .s_stb_o (s_stb_o),
      .s_cyc_o (s_cyc_o),
      .s_dat_i (s_dat_i),
      .s_ack_i (s_ack_i),
      .s_err_i (s_err_i),
      .gnt_o   (gnt_o),
      .busy_o  (busy_o)
   );

   typedef struct {
      logic [1:0]  cyc, stb, we;
      logic [63:0] a0, a1, d1;
      logic        ack, err;
      logic [63:0] sdat;
      logic [1:0]  e_gnt;
      logic        e_cyc, e_stb, e_we;
      logic [63:0] e_adr, e_dat;
      logic [1:0]  e_ack, e_err;
   } vec_t;

   localparam logic [63:0] A0 = 64'h0000_8000_0000_0000;
   localparam logic [63:0] D0 = 64'h0000_0000_0000_1111;
   localparam logic [63:0] RD = 64'hDEAD_BEEF_0000_0001;

   vec_t tbl [16];

   function automatic vec_t mk(
      input logic [1:0] c, s, w,
      input logic [63:0] a0, a1, d1,
      input logic ack, err,
      input logic [63:0] sd,
      input logic [1:0] eg,
      input logic ec, es, ew,
      input logic [63:0] ea, ed,
      input logic [1:0] eak, eer
   );
      vec_t v;
      v.cyc = c; v.stb = s; v.we = w;
      v.a0 = a0; v.a1 = a1; v.d1 = d1;
      v.ack = ack; v.err = err; v.sdat = sd;
      v.e_gnt = eg; v.e_cyc = ec; v.e_stb = es; v.e_we = ew;
      v.e_adr = ea; v.e_dat = ed; v.e_ack = eak; v.e_err = eer;
      return v;
   endfunction

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic [1:0] c, input logic [1:0] s);
      @(negedge clk_i);
      cyc = c;
      stb = s;
      #2;
   endtask

   initial begin
      cyc = '0; stb = '0; we = '0;
      adr0 = '0; adr1 = '0; dat0 = D0; dat1 = '0;
      sel0 = 8'h0F; sel1 = 8'hFF;
      s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;

      tbl[0]  = mk(2'b00,2'b00,2'b00, 0,0,0, 0,0,0,
                   2'b00,0,0,0, 0,0, 2'b00,2'b00);
      tbl[1]  = mk(2'b01,2'b01,2'b00, A0,0,0, 0,0,0,
                   2'b00,0,0,0, 0,0, 2'b00,2'b00);
      tbl[2]  = mk(2'b01,2'b01,2'b00, A0,0,0, 0,0,0,
                   2'b01,1,1,0, A0,D0, 2'b00,2'b00);
      tbl[3]  = mk(2'b01,2'b01,2'b00, A0,0,0, 1,0,RD,
                   2'b01,1,1,0, A0,D0, 2'b01,2'b00);
      tbl[4]  = mk(2'b00,2'b00,2'b00, A0,0,0, 0,0,0,
                   2'b01,0,0,0, A0,D0, 2'b00,2'b00);
      tbl[5]  = mk(2'b11,2'b11,2'b10, 64'h2000,64'h1000,64'h5A, 0,0,0,
                   2'b00,0,0,0, 0,0, 2'b00,2'b00);
      tbl[6]  = mk(2'b11,2'b11,2'b10, 64'h2000,64'h1000,64'h5A, 0,0,0,
                   2'b10,1,1,1, 64'h1000,64'h5A, 2'b00,2'b00);
      tbl[7]  = mk(2'b11,2'b11,2'b10, 64'h2000,64'h1000,64'h5A, 1,0,64'h77,
                   2'b10,1,1,1, 64'h1000,64'h5A, 2'b10,2'b00);
      tbl[8]  = mk(2'b01,2'b01,2'b00, 64'h2000,64'h1000,64'h5A, 0,0,0,
                   2'b10,0,0,0, 64'h1000,64'h5A, 2'b00,2'b00);
      tbl[9]  = mk(2'b01,2'b01,2'b00, 64'h2000,64'h1000,64'h5A, 0,0,0,
                   2'b00,0,0,0, 0,0, 2'b00,2'b00);
      tbl[10] = mk(2'b11,2'b11,2'b10, 64'h2000,64'h1000,64'h5A, 0,0,0,
                   2'b01,1,1,0, 64'h2000,D0, 2'b00,2'b00);
      tbl[11] = mk(2'b10,2'b10,2'b10, 64'h2000,64'h1000,64'h5A, 0,0,0,
                   2'b01,0,0,0, 64'h2000,D0, 2'b00,2'b00);
      tbl[12] = mk(2'b10,2'b10,2'b10, 64'h2000,64'h1000,64'h5A, 0,0,0,
                   2'b00,0,0,0, 0,0, 2'b00,2'b00);
      tbl[13] = mk(2'b10,2'b10,2'b10, 64'h2000,64'h1000,64'h5A, 0,1,64'h33,
                   2'b10,1,1,1, 64'h1000,64'h5A, 2'b00,2'b10);
      tbl[14] = mk(2'b00,2'b00,2'b00, 64'h2000,64'h1000,64'h5A, 0,0,0,
                   2'b10,0,0,0, 64'h1000,64'h5A, 2'b00,2'b00);
      tbl[15] = mk(2'b00,2'b00,2'b00, 0,0,0, 0,0,0,
                   2'b00,0,0,0, 0,0, 2'b00,2'b00);

      // reset state
      #2;
      chk("rst_gnt", 64'(gnt_o), 0);
      chk("rst_busy", 64'(busy_o), 0);
      chk("rst_scyc", 64'(s_cyc_o), 0);
      chk("rst_sadr", s_adr_o, 0);
      chk("rst_ack", 64'(m_ack_o), 0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;

      for (int i = 0; i < 16; i++) begin
         @(negedge clk_i);
         cyc = tbl[i].cyc; stb = tbl[i].stb; we = tbl[i].we;
         adr0 = tbl[i].a0; adr1 = tbl[i].a1; dat1 = tbl[i].d1;
         s_ack_i = tbl[i].ack; s_err_i = tbl[i].err;
         s_dat_i = tbl[i].sdat;
         #2;
         chk($sformatf("v%0d_gnt", i), 64'(gnt_o), 64'(tbl[i].e_gnt));
         chk($sformatf("v%0d_busy", i), 64'(busy_o),
             64'(tbl[i].e_gnt != 2'b00));
         chk($sformatf("v%0d_scyc", i), 64'(s_cyc_o), 64'(tbl[i].e_cyc));
         chk($sformatf("v%0d_sstb", i), 64'(s_stb_o), 64'(tbl[i].e_stb));
         chk($sformatf("v%0d_swe", i), 64'(s_we_o), 64'(tbl[i].e_we));
         chk($sformatf("v%0d_sadr", i), s_adr_o, tbl[i].e_adr);
         chk($sformatf("v%0d_sdat", i), s_dat_o, tbl[i].e_dat);
         chk($sformatf("v%0d_mack", i), 64'(m_ack_o), 64'(tbl[i].e_ack));
         chk($sformatf("v%0d_merr", i), 64'(m_err_o), 64'(tbl[i].e_err));
         chk($sformatf("v%0d_mdat", i), m_dat_o, tbl[i].sdat);
      end
      s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
      adr0 = 64'h40; adr1 = 64'h80; we = 2'b00;

      // async reset mid-transaction, then master 0 must win first
      step(2'b10, 2'b10);
      step(2'b10, 2'b10);
      chk("pre_rst_gnt", 64'(gnt_o), 2);
      chk("pre_rst_sel", 64'(s_sel_o), 64'hFF);
      rst_i = 1'b1;
      #1;
      chk("mid_rst_scyc", 64'(s_cyc_o), 0);
      chk("mid_rst_sstb", 64'(s_stb_o), 0);
      chk("mid_rst_gnt", 64'(gnt_o), 0);
      chk("mid_rst_busy", 64'(busy_o), 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      cyc = 2'b11; stb = 2'b11;
      step(2'b11, 2'b11);
      chk("post_rst_gnt", 64'(gnt_o), 1);
      chk("post_rst_sadr", s_adr_o, 64'h40);
      chk("post_rst_sel", 64'(s_sel_o), 64'h0F);
      // master 0 releases and re-requests at once: goes behind master 1
      step(2'b10, 2'b10);
      chk("rel0_scyc", 64'(s_cyc_o), 0);
      step(2'b11, 2'b11);
      chk("idle_gnt", 64'(gnt_o), 0);
      chk("idle_scyc", 64'(s_cyc_o), 0);
      step(2'b11, 2'b11);
      chk("fair_gnt1", 64'(gnt_o), 2);
      step(2'b01, 2'b01);
      step(2'b01, 2'b01);
      chk("fair_idle", 64'(gnt_o), 0);
      step(2'b01, 2'b01);
      chk("fair_gnt0", 64'(gnt_o), 1);
      step(2'b00, 2'b00);
      step(2'b00, 2'b00);
      chk("fair_end_busy", 64'(busy_o), 0);

      // slave never answers
      step(2'b01, 2'b01);
      for (int i = 0; i < 4; i++) begin
         step(2'b01, 2'b01);
         chk($sformatf("stall%0d_err", i), 64'(m_err_o), 0);
         chk($sformatf("stall%0d_scyc", i), 64'(s_cyc_o), 1);
      end
`ifdef WB_ARB_TIMEOUT_EN
      step(2'b01, 2'b01);
      chk("tmo_pulse", 64'(m_err_o), 1);
      s_ack_i = 1'b1;
      step(2'b01, 2'b01);
      chk("hold_err", 64'(m_err_o), 0);
      chk("hold_ack", 64'(m_ack_o), 0);
      chk("hold_scyc", 64'(s_cyc_o), 0);
      chk("hold_sstb", 64'(s_stb_o), 0);
      chk("hold_busy", 64'(busy_o), 1);
      step(2'b01, 2'b01);
      chk("hold2_scyc", 64'(s_cyc_o), 0);
      s_ack_i = 1'b0;
`else
      begin
         int bad;
         bad = 0;
         for (int i = 0; i < 300; i++) begin
            step(2'b01, 2'b01);
            if (m_err_o != 2'b00 || s_cyc_o != 1'b1) bad++;
         end
         chk("no_tmo_bad", 64'(bad), 0);
         chk("no_tmo_scyc", 64'(s_cyc_o), 1);
      end
`endif
      step(2'b00, 2'b00);
      step(2'b00, 2'b00);
      chk("tmo_end_busy", 64'(busy_o), 0);
      chk("tmo_end_gnt", 64'(gnt_o), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
